// File: rtl/fpu_scheduler.sv
// fpu_scheduler: round-robin front end that shares one fpu between NREQ requesters.
// Optional build macro: FPU_SCHED_TIMEOUT_EN adds a WAIT-state watchdog and the rspTimeout port.

package fpu_pkg;
    typedef logic [15:0] fp16_t;

    typedef enum logic [2:0] {
        FPU_ADD  = 3'd0,
        FPU_SUB  = 3'd1,
        FPU_MUL  = 3'd2,
        FPU_DIV  = 3'd3,
        FPU_FMAD = 3'd4,
        FPU_FMS  = 3'd5
    } fpuOp_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } statusFlag_t;

    typedef logic [3:0] condCode_t;
endpackage

module fpu_scheduler
    import fpu_pkg::*;
#(
    parameter type         FP_T    = fp16_t,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned WIDTH  = $bits(FP_T),
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]  reqValid,
    output logic [NREQ-1:0]  reqReady,
    input  fpuOp_t           reqOp  [NREQ],
    input  FP_T              reqIn1 [NREQ],
    input  FP_T              reqIn2 [NREQ],
    input  FP_T              reqIn3 [NREQ],
    output logic             rspValid,
    input  logic             rspReady,
    output logic [IDW-1:0]   rspId,
    output FP_T              rspData,
    output statusFlag_t      rspFlags,
    output condCode_t        rspCond,
`ifdef FPU_SCHED_TIMEOUT_EN
    output logic             rspTimeout,
`endif
    output FP_T              fpuIn1,
    output FP_T              fpuIn2,
    output FP_T              fpuIn3,
    output fpuOp_t           fpuOp,
    output logic             fpuStart,
    output logic             fpuReset,
    input  logic             fpuDone,
    input  FP_T              fpuOut,
    input  statusFlag_t      fpuFlags,
    input  condCode_t        fpuCond
);

    // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set (7E00 for fp16)
    localparam int unsigned EXPW = (WIDTH >= 64) ? 11 : (WIDTH >= 32) ? 8 : 5;
    localparam logic [WIDTH-1:0] CANON_NAN =
        {1'b0, {EXPW{1'b1}}, 1'b1, {(WIDTH - EXPW - 2){1'b0}}};

    // Reject configurations the arbiter and watchdog cannot support
    if (NREQ < 2 || TIMEOUT < 1) begin : g_cfg_check
        $error("fpu_scheduler: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        SETTLE = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t          state, next_state;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant_c;
    logic [IDW-1:0]  win_c;
    logic            grant_any_c;
    logic            cap_fpu_c;
    logic            cap_nan_c;

    fpuOp_t          op_q;
    FP_T             in1_q, in2_q, in3_q;
    logic [IDW-1:0]  id_q;
    logic            start_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    FP_T             rsp_data_q;
    statusFlag_t     rsp_flags_q;
    condCode_t       rsp_cond_q;

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] wait_cnt;
    logic            to_c;
    logic            timeout_q;
    assign rspTimeout = timeout_q;
`endif

    assign reqReady = grant_c;
    assign rspValid = rsp_valid_q;
    assign rspId    = rsp_id_q;
    assign rspData  = rsp_data_q;
    assign rspFlags = rsp_flags_q;
    assign rspCond  = rsp_cond_q;
    assign fpuIn1   = in1_q;
    assign fpuIn2   = in2_q;
    assign fpuIn3   = in3_q;
    assign fpuOp    = op_q;
    assign fpuStart = start_q;
    assign fpuReset = reset | (state == CLEAR);

    // Round-robin winner search starting at ptr, only offered while IDLE
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_c     = '0;
        win_c       = '0;
        grant_any_c = 1'b0;
        if (state == IDLE && !reset) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                idx = (32'(ptr) + i) % NREQ;
                if (!grant_any_c && reqValid[IDW'(idx)]) begin
                    grant_any_c = 1'b1;
                    win_c       = IDW'(idx);
                end
            end
            grant_c[win_c] = grant_any_c;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and response capture strobes
    always_comb begin
        next_state = state;
        cap_fpu_c  = 1'b0;
        cap_nan_c  = 1'b0;
`ifdef FPU_SCHED_TIMEOUT_EN
        to_c       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (grant_any_c) begin
                    case (reqOp[win_c])
                        FPU_ADD, FPU_SUB:                   next_state = SETTLE;
                        FPU_MUL, FPU_DIV, FPU_FMAD, FPU_FMS: next_state = CLEAR;
                        default: begin
                            next_state = RESP;
                            cap_nan_c  = 1'b1;
                        end
                    endcase
                end
            end
            CLEAR:  next_state = ISSUE;
            ISSUE:  next_state = WAIT;
            WAIT: begin
                if (fpuDone) begin
                    next_state = RESP;
                    cap_fpu_c  = 1'b1;
                end
`ifdef FPU_SCHED_TIMEOUT_EN
                else if (wait_cnt == CNTW'(TIMEOUT - 1)) begin
                    next_state = RESP;
                    cap_nan_c  = 1'b1;
                    to_c       = 1'b1;
                end
`endif
            end
            SETTLE: begin
                next_state = RESP;
                cap_fpu_c  = 1'b1;
            end
            RESP: begin
                if (rspReady) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operation latch, arbitration pointer, FPU start and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            op_q        <= FPU_ADD;
            in1_q       <= '0;
            in2_q       <= '0;
            in3_q       <= '0;
            id_q        <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_cond_q  <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            if (grant_any_c) begin
                op_q  <= reqOp[win_c];
                in1_q <= reqIn1[win_c];
                in2_q <= reqIn2[win_c];
                in3_q <= reqIn3[win_c];
                id_q  <= win_c;
                ptr   <= (32'(win_c) == NREQ - 1) ? '0 : win_c + IDW'(1);
`ifdef FPU_SCHED_TIMEOUT_EN
                timeout_q <= 1'b0;
`endif
            end
            start_q     <= (next_state == ISSUE);
            rsp_valid_q <= (next_state == RESP);
            if (cap_fpu_c) begin
                rsp_id_q    <= id_q;
                rsp_data_q  <= fpuOut;
                rsp_flags_q <= fpuFlags;
                rsp_cond_q  <= fpuCond;
            end
            if (cap_nan_c) begin
                // Unsupported op is rejected straight from IDLE, before id_q is loaded
                rsp_id_q    <= (state == IDLE) ? win_c : id_q;
                rsp_data_q  <= CANON_NAN;
                rsp_flags_q <= '{nv: 1'b1, default: 1'b0};
                rsp_cond_q  <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
                timeout_q   <= to_c;
`endif
            end
        end
    end

`ifdef FPU_SCHED_TIMEOUT_EN
    // Count cycles spent waiting on fpuDone
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              wait_cnt <= '0;
        else if (state != WAIT) wait_cnt <= '0;
        else                    wait_cnt <= wait_cnt + CNTW'(1);
    end
`endif

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed bench for fpu_scheduler with a small table-driven fpu stub.
module tb_fpu_scheduler;
    import fpu_pkg::*;

    localparam int TO_CYCLES = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  reqValid;
    logic [3:0]  reqReady;
    fpuOp_t      reqOp  [4];
    fp16_t       reqIn1 [4];
    fp16_t       reqIn2 [4];
    fp16_t       reqIn3 [4];
    logic        rspValid;
    logic        rspReady;
    logic [1:0]  rspId;
    fp16_t       rspData;
    statusFlag_t rspFlags;
    condCode_t   rspCond;
`ifdef FPU_SCHED_TIMEOUT_EN
    logic        rspTimeout;
`endif
    fp16_t       fpuIn1, fpuIn2, fpuIn3;
    fpuOp_t      fpuOp;
    logic        fpuStart;
    logic        fpuReset;
    logic        fpuDone;
    fp16_t       fpuOut;
    statusFlag_t fpuFlags;
    condCode_t   fpuCond;

    int n_checks = 0;
    int n_fail   = 0;
    int n_clr    = 0;
    int n_start  = 0;
    int onehot_err = 0;

    fpu_scheduler #(.FP_T(fp16_t), .NREQ(4), .TIMEOUT(TO_CYCLES)) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqIn1(reqIn1), .reqIn2(reqIn2), .reqIn3(reqIn3),
        .rspValid(rspValid), .rspReady(rspReady), .rspId(rspId),
        .rspData(rspData), .rspFlags(rspFlags), .rspCond(rspCond),
`ifdef FPU_SCHED_TIMEOUT_EN
        .rspTimeout(rspTimeout),
`endif
        .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuIn3(fpuIn3), .fpuOp(fpuOp),
        .fpuStart(fpuStart), .fpuReset(fpuReset), .fpuDone(fpuDone),
        .fpuOut(fpuOut), .fpuFlags(fpuFlags), .fpuCond(fpuCond)
    );

    always #5 clock = ~clock;

    // Hand-computed fp16 results for the operand sets used below
    function automatic fp16_t ref_fpu(fpuOp_t op, fp16_t a, fp16_t b, fp16_t c);
        fp16_t r;
        r = 16'hDEAD;
        case (op)
            FPU_ADD:  if (a == 16'h3C00 && b == 16'h4000) r = 16'h4200;
            FPU_SUB:  if (a == 16'h4200 && b == 16'h3C00) r = 16'h4000;
            FPU_MUL:  if (a == 16'h4000 && b == 16'h4200) r = 16'h4600;
            FPU_DIV:  if (a == 16'h4200 && b == 16'h4000) r = 16'h3E00;
            FPU_FMAD: if (a == 16'h4000 && b == 16'h4200 && c == 16'h3C00) r = 16'h4700;
            FPU_FMS:  if (a == 16'h4000 && b == 16'h4200 && c == 16'h3C00) r = 16'h4500;
            default:  r = 16'hDEAD;
        endcase
        return r;
    endfunction

    // FPU stub: ADD/SUB combinational, others answer with a done pulse 4 cycles into WAIT
    logic stub_busy, stub_done, stub_hang, stub_out_ok;
    int   stub_cnt;
    always @(posedge clock) begin
        if (fpuReset) begin
            stub_busy <= 1'b0; stub_cnt <= 0; stub_done <= 1'b0;
        end else if (fpuStart) begin
            stub_busy <= 1'b1; stub_cnt <= 3; stub_done <= 1'b0;
        end else if (stub_busy) begin
            if (stub_cnt == 1) begin
                stub_busy <= 1'b0;
                stub_done <= !stub_hang;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end else begin
            stub_done <= 1'b0;
        end
    end
    assign stub_out_ok = (fpuOp == FPU_ADD) || (fpuOp == FPU_SUB) || stub_done;
    assign fpuDone  = stub_done;
    assign fpuOut   = stub_out_ok ? ref_fpu(fpuOp, fpuIn1, fpuIn2, fpuIn3) : 16'hBAD0;
    assign fpuFlags = stub_out_ok ? statusFlag_t'(5'b00000) : statusFlag_t'(5'b01111);
    assign fpuCond  = stub_out_ok ? 4'h2 : 4'hF;

    // Pulse counters and grant one-hot monitor
    always @(posedge clock) begin
        if (!reset) begin
            if (fpuReset) n_clr   <= n_clr + 1;
            if (fpuStart) n_start <= n_start + 1;
        end
    end
    always @(negedge clock) begin
        #2;
        if ($countones(reqReady) > 1) onehot_err <= onehot_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op from a lone requester and check the response it produces
    task automatic do_op(input int id, input fpuOp_t op, input fp16_t a, input fp16_t b,
                         input fp16_t c, input fp16_t exp_d, input logic [4:0] exp_f,
                         input int exp_lat, input int exp_pulses, input logic chk_cond);
        int lat, c0, s0;
        logic [3:0] oh;
        oh = 4'(1) << id;
        @(negedge clock);
        reqOp[id] = op; reqIn1[id] = a; reqIn2[id] = b; reqIn3[id] = c;
        reqValid[id] = 1'b1;
        #1;
        check("grant", 32'(reqReady), 32'(oh));
        c0 = n_clr; s0 = n_start;
        @(posedge clock);
        @(negedge clock);
        reqValid[id] = 1'b0;
        lat = 1;
        while (!rspValid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rspData", 32'(rspData), 32'(exp_d));
        check("rspId", 32'(rspId), 32'(id));
        check("rspFlags", 32'(rspFlags), 32'(exp_f));
        if (chk_cond) check("rspCond", 32'(rspCond), 32'h2);
        check("clr_pulses", 32'(n_clr - c0), 32'(exp_pulses));
        check("start_pulses", 32'(n_start - s0), 32'(exp_pulses));
        @(negedge clock);
        check("rsp_done", 32'(rspValid), 32'h0);
    endtask

    initial begin
        int order [5];
        int gcyc  [5];
        int rids  [4];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int ngr, nrsp, pend, bad, seen, w, lat;

        reset = 1'b1; reqValid = 4'b1111; rspReady = 1'b1; stub_hang = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reqOp[i] = FPU_ADD; reqIn1[i] = 16'h3C00; reqIn2[i] = 16'h4000; reqIn3[i] = '0;
        end
        repeat (2) @(negedge clock);
        check("rst_reqReady", 32'(reqReady), 32'h0);
        check("rst_rspValid", 32'(rspValid), 32'h0);
        check("rst_fpuStart", 32'(fpuStart), 32'h0);
        check("rst_rspData", 32'(rspData), 32'h0);
        check("rst_rspId", 32'(rspId), 32'h0);
        check("rst_fpuOp", 32'(fpuOp), 32'(FPU_ADD));
        check("rst_fpuIn1", 32'(fpuIn1), 32'h0);
        check("rst_fpuReset", 32'(fpuReset), 32'h1);
        reqValid = 4'b0000;
        reset = 1'b0;
        @(negedge clock);
        check("fpuReset_idle", 32'(fpuReset), 32'h0);

        do_op(0, FPU_ADD,  16'h3C00, 16'h4000, 16'h0000, 16'h4200, 5'b00000, 2, 0, 1'b1);
        do_op(2, FPU_MUL,  16'h4000, 16'h4200, 16'h0000, 16'h4600, 5'b00000, 7, 1, 1'b1);
        do_op(1, FPU_DIV,  16'h4200, 16'h4000, 16'h0000, 16'h3E00, 5'b00000, 7, 1, 1'b1);
        do_op(3, FPU_FMAD, 16'h4000, 16'h4200, 16'h3C00, 16'h4700, 5'b00000, 7, 1, 1'b1);
        do_op(3, FPU_FMS,  16'h4000, 16'h4200, 16'h3C00, 16'h4500, 5'b00000, 7, 1, 1'b1);
        do_op(3, fpuOp_t'(3'd7), 16'h0001, 16'h0002, 16'h0003, 16'h7E00, 5'b10000, 1, 0, 1'b0);

        // All four request ADD at once; req0 stays valid for a second round
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            reqOp[i] = FPU_ADD; reqIn1[i] = 16'h3C00; reqIn2[i] = 16'h4000;
        end
        reqValid = 4'b1111;
        ngr = 0; nrsp = 0;
        for (int cyc = 0; cyc < 40 && ngr < 5; cyc++) begin
            #1;
            pend = -1;
            if (rspValid && nrsp < 4) begin
                rids[nrsp] = int'(rspId);
                nrsp++;
            end
            if (reqReady != 4'b0000) begin
                w = 0;
                for (int k = 0; k < 4; k++) if (reqReady[k]) w = k;
                order[ngr] = w;
                gcyc[ngr]  = cyc;
                ngr++;
                pend = w;
            end
            @(negedge clock);
            if (pend > 0) reqValid[pend] = 1'b0;
        end
        check("rr_grants", 32'(ngr), 32'd5);
        for (int k = 0; k < 5; k++) if (k < ngr) check("rr_order", 32'(order[k]), 32'(exp_order[k]));
        check("rr_rsp_count", 32'(nrsp), 32'd4);
        for (int k = 0; k < 4; k++) if (k < nrsp) check("rr_rspId", 32'(rids[k]), 32'(k));
        if (ngr >= 2) check("rr_gap", 32'(gcyc[1] - gcyc[0]), 32'd3);
        reqValid = 4'b0000;
        repeat (4) @(negedge clock);
        check("rr_onehot", 32'(onehot_err), 32'h0);

        // Backpressure: hold rspReady low for 5 cycles with req2 waiting
        rspReady = 1'b0;
        reqOp[1] = FPU_SUB; reqIn1[1] = 16'h4200; reqIn2[1] = 16'h3C00;
        reqValid[1] = 1'b1;
        #1;
        check("bp_grant", 32'(reqReady), 32'b0010);
        @(posedge clock);
        @(negedge clock);
        reqValid[1] = 1'b0;
        reqValid[2] = 1'b1;
        lat = 1;
        while (!rspValid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd2);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (!rspValid || rspData != 16'h4000 || rspId != 2'd1 || reqReady != 4'b0000) bad++;
            @(negedge clock);
        end
        check("bp_hold", 32'(bad), 32'h0);
        rspReady = 1'b1;
        #1;
        check("bp_still_valid", 32'(rspValid), 32'h1);
        @(negedge clock);
        check("bp_complete", 32'(rspValid), 32'h0);
        #1;
        check("bp_next_grant", 32'(reqReady), 32'b0100);
        @(posedge clock);
        @(negedge clock);
        reqValid[2] = 1'b0;
        lat = 1;
        while (!rspValid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check("bp2_data", 32'(rspData), 32'h4200);
        check("bp2_id", 32'(rspId), 32'h2);
        @(negedge clock);

        // Reset during WAIT aborts the op silently
        stub_hang = 1'b1;
        reqOp[0] = FPU_MUL; reqIn1[0] = 16'h4000; reqIn2[0] = 16'h4200;
        reqValid[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reqValid[0] = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        check("wrst_fpuReset", 32'(fpuReset), 32'h1);
        @(negedge clock);
        check("wrst_fpuOp", 32'(fpuOp), 32'(FPU_ADD));
        check("wrst_fpuIn2", 32'(fpuIn2), 32'h0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (rspValid) seen++;
        end
        check("wrst_no_rsp", 32'(seen), 32'h0);
        stub_hang = 1'b0;
        reqOp[0] = FPU_ADD; reqOp[1] = FPU_ADD;
        reqIn1[0] = 16'h3C00; reqIn2[0] = 16'h4000;
        reqValid = 4'b0011;
        #1;
        check("wrst_ptr", 32'(reqReady), 32'b0001);
        reqValid = 4'b0000;
        do_op(0, FPU_ADD, 16'h3C00, 16'h4000, 16'h0000, 16'h4200, 5'b00000, 2, 0, 1'b1);

`ifdef FPU_SCHED_TIMEOUT_EN
        stub_hang = 1'b1;
        do_op(2, FPU_MUL, 16'h4000, 16'h4200, 16'h0000, 16'h7E00, 5'b10000, 3 + TO_CYCLES, 1, 1'b0);
        check("to_flag_held", 32'(rspTimeout), 32'h1);
        stub_hang = 1'b0;
        do_op(1, FPU_ADD, 16'h3C00, 16'h4000, 16'h0000, 16'h4200, 5'b00000, 2, 0, 1'b1);
        check("to_flag_cleared", 32'(rspTimeout), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
